// File: rtl/ssm2603_i2c_ctrl_if.sv
// Local-bus register port for the SSM2603 I2C controller.
// master issues strobes; slave returns acks and read data.
interface ssm2603_i2c_ctrl_if #(
  parameter int LB_DATA_W = 32,
  parameter int LB_ADDR_W = 8
);
  logic                 lb_wr_en;
  logic                 lb_rd_en;
  logic [LB_ADDR_W-1:0] lb_addr;
  logic [LB_DATA_W-1:0] lb_wr_data;
  logic                 lb_wr_valid;
  logic                 lb_rd_valid;
  logic [LB_DATA_W-1:0] lb_rd_data;

  modport master (
    output lb_wr_en, lb_rd_en,
    output lb_addr, lb_wr_data,
    input  lb_wr_valid, lb_rd_valid,
    input  lb_rd_data
  );

  modport slave (
    input  lb_wr_en, lb_rd_en,
    input  lb_addr, lb_wr_data,
    output lb_wr_valid, lb_rd_valid,
    output lb_rd_data
  );
endinterface

// File: rtl/ssm2603_i2c_ctrl.sv
// SSM2603 codec register programmer: local-bus word in,
// 3-byte open-drain I2C write out (addr, word[15:8], word[7:0]).
module ssm2603_i2c_ctrl #(
  parameter int       LB_DATA_W = 32,
  parameter int       LB_ADDR_W = 8,
  parameter int       CLK_DIV_W = 16,
  parameter bit [6:0] DEV_ADDR  = 7'h1A
) (
  input  logic clk,
  input  logic rst_n,
  ssm2603_i2c_ctrl_if.slave lb,
  output logic cfg_done,
  output logic I2C_SCLK_OE,
  output logic I2C_SDAT_OE,
  input  logic I2C_SDAT_I
);

  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {
    IDLE_S, START_S, BIT_S, ACK_S, STOP_S
  } state_t;

  state_t state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [CLK_DIV_W-1:0] cnt_q, cnt_d;
  logic [CLK_DIV_W-1:0] div_act_q, div_act_d;
  logic [CLK_DIV_W-1:0] clk_div_q, clk_div_d;
  logic [15:0] xfer_q, xfer_d;
  logic ack_q, ack_d;
  logic nack_q, nack_d;
  logic done_q, done_d;
  logic cfg_done_q, cfg_done_d;
  logic scl_q, scl_d;
  logic sda_q, sda_d;
  logic sda_s1_q, sda_s2_q;
  logic wr_vld_q, rd_vld_q;
  logic [LB_DATA_W-1:0] rd_data_q, rd_data_d;

  logic busy, qtck, xfer_acc;
  logic sel_status, sel_div, sel_xfer;
  logic [7:0] cur_byte;
  logic cur_bit;
  logic unused_wr_bits;

  assign unused_wr_bits = ^lb.lb_wr_data;

  assign sel_status = lb.lb_addr == LB_ADDR_W'(0);
  assign sel_div    = lb.lb_addr == LB_ADDR_W'(1);
  assign sel_xfer   = lb.lb_addr == LB_ADDR_W'(2);

  assign busy     = state_q != IDLE_S;
  assign qtck     = busy && (cnt_q == div_act_q);
  assign xfer_acc = lb.lb_wr_en && sel_xfer && !busy;

  always_comb begin
    unique case (byte_q)
      2'd0:    cur_byte = ADDR_BYTE;
      2'd1:    cur_byte = xfer_q[15:8];
      default: cur_byte = xfer_q[7:0];
    endcase
  end
  assign cur_bit = cur_byte[bit_q];

  always_comb begin
    rd_data_d = rd_data_q;
    if (lb.lb_rd_en) begin
      rd_data_d = LB_DATA_W'(32'hdeadbabe);
      unique case (1'b1)
        sel_status:
          rd_data_d = LB_DATA_W'({done_q, nack_q, busy});
        sel_div:  rd_data_d = LB_DATA_W'(clk_div_q);
        sel_xfer: rd_data_d = LB_DATA_W'(xfer_q);
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    ack_d      = ack_q;
    nack_d     = nack_q;
    done_d     = done_q;
    cfg_done_d = 1'b0;
    xfer_d     = xfer_q;
    clk_div_d  = clk_div_q;

    if (lb.lb_wr_en && sel_div)
      clk_div_d = lb.lb_wr_data[CLK_DIV_W-1:0];
    if (xfer_acc) begin
      xfer_d = lb.lb_wr_data[15:0];
      nack_d = 1'b0;
      done_d = 1'b0;
    end

    // divider reloads only at quarter boundaries
    if (!busy || qtck) begin
      cnt_d     = '0;
      div_act_d = clk_div_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE_S: if (xfer_acc) begin
        state_d = START_S;
        qtr_d   = 2'd0;
        byte_d  = 2'd0;
        bit_d   = 3'd7;
      end
      START_S: if (qtck) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd1) begin
          state_d = BIT_S;
          qtr_d   = 2'd0;
        end
      end
      BIT_S: if (qtck) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = ACK_S;
        end
      end
      ACK_S: if (qtck) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd2) ack_d = sda_s2_q;
        if (qtr_q == 2'd3) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = STOP_S;
          end else if (byte_q == 2'd2) begin
            state_d = STOP_S;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
            state_d = BIT_S;
          end
        end
      end
      STOP_S: if (qtck) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          state_d    = IDLE_S;
          done_d     = 1'b1;
          cfg_done_d = 1'b1;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // pad drive follows the current quarter, one clk late
  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_q)
      START_S: sda_d = 1'b1;
      BIT_S: begin
        scl_d = ~qtr_q[1];
        sda_d = ~cur_bit;
      end
      ACK_S: scl_d = ~qtr_q[1];
      STOP_S: begin
        scl_d = qtr_q == 2'd0;
        sda_d = ~qtr_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_S;
      qtr_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      cnt_q      <= '0;
      div_act_q  <= CLK_DIV_W'(124);
      clk_div_q  <= CLK_DIV_W'(124);
      xfer_q     <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      scl_q      <= 1'b0;
      sda_q      <= 1'b0;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      clk_div_q  <= clk_div_d;
      xfer_q     <= xfer_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      cfg_done_q <= cfg_done_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      sda_s1_q   <= I2C_SDAT_I;
      sda_s2_q   <= sda_s1_q;
      wr_vld_q   <= lb.lb_wr_en;
      rd_vld_q   <= lb.lb_rd_en;
      rd_data_q  <= rd_data_d;
    end
  end

  assign lb.lb_wr_valid = wr_vld_q;
  assign lb.lb_rd_valid = rd_vld_q;
  assign lb.lb_rd_data  = rd_data_q;
  assign cfg_done       = cfg_done_q;
  assign I2C_SCLK_OE    = scl_q;
  assign I2C_SDAT_OE    = sda_q;

endmodule
